// File: rtl/uop_sequencer.sv
// Instruction-level controller for the multi-cycle CPU datapath: walks each
// instruction through fetch, decode and 0..MAX_OPS select/exec/load micro-ops.
module uop_sequencer #(
  parameter int MAX_OPS = 3,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_en,
  input  logic               mem_ready,
  input  logic               halt_req,
  input  logic [3:0]         num_of_ope,
  input  logic [3:0]         select_1,
  input  logic [3:0]         select_2,
  input  logic [3:0]         select_3,
  input  logic [3:0]         reg_load_1,
  input  logic [3:0]         reg_load_2,
  input  logic [3:0]         reg_load_3,
  output logic               fetch_req,
  output logic               fetch_strobe,
  output logic               decode_strobe,
  output logic               select_strobe,
  output logic               exec_strobe,
  output logic               load_strobe,
  output logic               eip_strobe,
  output logic [1:0]         op_index,
  output logic [3:0]         cur_select,
  output logic [3:0]         cur_reg_load,
  output logic               busy,
  output logic               halted,
  output logic               err_bad_nops,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DISPATCH,
    S_SEL,
    S_EXEC,
    S_LOAD,
    S_RETIRE,
    S_HALTED
  } state_e;

  localparam logic [3:0] MAX_N = 4'(MAX_OPS);

  state_e               state_q, state_d;
  logic [3:0]           nops_q, nops_d;
  logic [1:0]           idx_q, idx_d;
  logic                 err_q, err_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 last_op;
  logic                 in_op;
  logic [3:0]           sel_op;
  logic [3:0]           load_op;

  assign last_op = ({2'b00, idx_q} == (nops_q - 4'd1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    nops_d  = nops_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (run_en) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_DISPATCH;
      S_DISPATCH: begin
        nops_d = num_of_ope;
        idx_d  = 2'd0;
        if (num_of_ope == 4'd0) begin
          state_d = S_RETIRE;
        end else if (num_of_ope <= MAX_N) begin
          state_d = S_SEL;
        end else begin
          err_d   = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_SEL:  state_d = S_EXEC;
      S_EXEC: state_d = S_LOAD;
      S_LOAD: begin
        if (last_op) begin
          state_d = S_RETIRE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_SEL;
        end
      end
      S_RETIRE: begin
        cnt_d = cnt_q + COUNT_W'(1);
        // halt_req is only honoured here, and it wins over run_en.
        if (halt_req)    state_d = S_HALTED;
        else if (run_en) state_d = S_FETCH;
        else             state_d = S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      nops_q  <= 4'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      nops_q  <= nops_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    begin sel_op = select_1; load_op = reg_load_1; end
      2'd1:    begin sel_op = select_2; load_op = reg_load_2; end
      default: begin sel_op = select_3; load_op = reg_load_3; end
    endcase
  end

  // Strobes decode straight from the state register, so an asynchronous reset
  // silences them immediately; fetch_strobe alone also looks at mem_ready.
  assign in_op         = (state_q == S_SEL) || (state_q == S_EXEC) || (state_q == S_LOAD);
  assign fetch_req     = (state_q == S_FETCH);
  assign fetch_strobe  = fetch_req && mem_ready;
  assign decode_strobe = (state_q == S_DECODE);
  assign select_strobe = (state_q == S_SEL);
  assign exec_strobe   = (state_q == S_EXEC);
  assign load_strobe   = (state_q == S_LOAD);
  assign eip_strobe    = (state_q == S_RETIRE);
  assign cur_select    = in_op ? sel_op : 4'd0;
  assign cur_reg_load  = load_strobe ? load_op : 4'd0;
  assign op_index      = idx_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted        = (state_q == S_HALTED);
  assign err_bad_nops  = err_q;
  assign instr_count   = cnt_q;

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Instruction-level controller for the multi-cycle CPU datapath; replaces the fixed 12-phase one-hot clocking with a state machine whose length depends on the decoded micro-op count.
- Emits single-cycle strobes to the fetch, decode, selector, ALU, register-load and EIP-update stages.
- Steps select_1..3 and reg_load_1..3 onto a single current-select bus and a single current-load bus, one micro-op at a time.
- Supports memory wait on fetch, halt and illegal-count trapping.

Parameters:
- MAX_OPS, 3, highest legal num_of_ope value (1..3).
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- run_en  in  1  1 = keep issuing instructions.
- mem_ready  in  1  instruction memory has valid ope this cycle.
- halt_req  in  1  stop after the current instruction retires.
- num_of_ope  in  4  micro-op count from decode.
- select_1, select_2, select_3  in  4 each  selector codes per micro-op.
- reg_load_1, reg_load_2, reg_load_3  in  4 each  destination-load codes per micro-op; 0 = no load.
- fetch_req  out  1  high throughout FETCH.
- fetch_strobe  out  1  fetch captures ope.
- decode_strobe  out  1  decode captures ope.
- select_strobe  out  1  selector samples cur_select.
- exec_strobe  out  1  ALU evaluates.
- load_strobe  out  1  destination register captures alu_result_bus.
- eip_strobe  out  1  EIP advances by num_of_ope.
- op_index  out  2  current micro-op, 0..2.
- cur_select  out  4  active select code.
- cur_reg_load  out  4  active load code.
- busy  out  1  state not IDLE and not HALTED.
- halted  out  1  in HALTED.
- err_bad_nops  out  1  sticky illegal-count flag.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - State goes to IDLE.
  - All outputs 0, instr_count 0, err_bad_nops 0, latched count 0.
  - Reset asserted mid-instruction aborts the instruction; no strobe is emitted after reset asserts.
- States: IDLE, FETCH, DECODE, DISPATCH, SEL, EXEC, LOAD, RETIRE, HALTED.
- Transitions:
  - IDLE -> FETCH when run_en=1.
  - FETCH holds while mem_ready=0, with fetch_req=1.
  - In FETCH with mem_ready=1: fetch_strobe=1, next state DECODE.
  - DECODE: decode_strobe=1 for 1 cycle, then DISPATCH.
  - DISPATCH (1 cycle): latch n=num_of_ope; op_index<=0.
    - n=0 -> RETIRE.
    - 1<=n<=MAX_OPS -> SEL.
    - n>MAX_OPS -> err_bad_nops<=1, next HALTED; no eip_strobe.
  - SEL: select_strobe=1, then EXEC.
  - EXEC: exec_strobe=1, then LOAD.
  - LOAD: load_strobe=1.
    - op_index==n-1 -> RETIRE.
    - Otherwise op_index++ and return to SEL.
  - RETIRE: eip_strobe=1; instr_count++ (wraps modulo 2^COUNT_W).
    - halt_req=1 -> HALTED (halt_req has priority over run_en).
    - Else run_en=1 -> FETCH.
    - Else IDLE.
  - HALTED is absorbing until reset. halt_req is ignored in all states except RETIRE.
- Data muxing:
  - cur_select = select_{op_index+1} in SEL, EXEC and LOAD; 0 in all other states.
  - cur_reg_load = reg_load_{op_index+1} in LOAD only; 0 in all other states. A code of 0 passes through unchanged.
  - select_k and reg_load_k are read combinationally. The sequencer relies on decode holding them stable from DISPATCH through RETIRE.
  - num_of_ope changes after DISPATCH are ignored; the latched n is used.
- Strobes are mutually exclusive; at most one strobe is high in any cycle. All outputs are registered or decoded from the state register; no combinational path from inputs to strobes except fetch_strobe (depends on mem_ready).
- Latency with mem_ready=1: 4+3n cycles per instruction (n=3 -> 13 cycles; n=0 -> 4 cycles). Each mem_ready=0 cycle in FETCH adds 1.
- busy = 1 in FETCH..RETIRE; halted = 1 only in HALTED.

Test Plan:
- Reset low for 2 cycles, release, run_en=1, mem_ready=1, n=3, select=(1,2,3), reg_load=(4,5,6) -> strobe order fetch, decode, (sel, exec, load)x3, eip over 13 cycles. cur_select sequence is 1,2,3; cur_reg_load is 4,5,6 only in the LOAD cycles; instr_count=1.
- n=0 -> fetch, decode, DISPATCH, eip in 4 cycles; no select, exec or load strobes.
- mem_ready held 0 for 5 cycles in FETCH -> fetch_req=1 for 6 cycles, fetch_strobe exactly once, total 18 cycles for n=3.
- n=5 -> err_bad_nops=1, halted=1, no eip_strobe, instr_count unchanged; stays halted until reset, and reset clears both flags.
- halt_req pulsed during EXEC of op 0, then held 1 at RETIRE -> halt_req ignored in EXEC, HALTED entered after eip_strobe; run_en=0 at RETIRE with halt_req=0 -> IDLE.
- Reset asserted mid-LOAD of op 1 -> all outputs 0 asynchronously, before the next clk edge; with COUNT_W=4, 16 retirements wrap instr_count to 0.
